// File: rtl/udma_hyper_pkg.sv
// Shared types and helpers for the HyperBus uDMA transaction arbiter.
package udma_hyper_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        ACTIVE  = 2'd2,
        RECOVER = 2'd3
    } arb_state_e;

    // Width of a channel index; never below 1 bit so single-channel builds still have a port.
    function automatic int CH_ID_W(input int nb_ch);
        return (nb_ch > 1) ? $clog2(nb_ch) : 1;
    endfunction

endpackage

// File: rtl/udma_hyper_trans_arb_if.sv
// Channel-side and PHY-side handshake bundle of the HyperBus transaction arbiter.
// master: the arbiter itself; slave: the channel front-ends and PHY around it.
interface udma_hyper_trans_arb_if
    import udma_hyper_pkg::*;
#(
    parameter int NB_CH = 2,
    parameter int CMD_W = 64
) ();

    localparam int ID_W = CH_ID_W(NB_CH);

    logic [NB_CH-1:0]       ch_req;
    logic [NB_CH*CMD_W-1:0] ch_cmd;
    logic [NB_CH-1:0]       ch_gnt;
    logic [NB_CH-1:0]       ch_done;
    logic                   phy_valid;
    logic                   phy_ready;
    logic [CMD_W-1:0]       phy_cmd;
    logic [ID_W-1:0]        phy_ch_id;
    logic                   phy_done;

    modport master (
        input  ch_req, ch_cmd, phy_ready, phy_done,
        output ch_gnt, ch_done, phy_valid, phy_cmd, phy_ch_id
    );

    modport slave (
        output ch_req, ch_cmd, phy_ready, phy_done,
        input  ch_gnt, ch_done, phy_valid, phy_cmd, phy_ch_id
    );

endinterface

// File: rtl/udma_hyper_rr_arb.sv
// Combinational channel picker: request vector + pointer -> one-hot grant + index.
// Build option UDMA_HYPER_ARB_FIXED_PRIO_EN: fixed priority (lowest index wins),
// no pointer input; otherwise round-robin starting at the pointer.
module udma_hyper_rr_arb
    import udma_hyper_pkg::*;
#(
    parameter  int NB_CH = 2,
    localparam int ID_W  = CH_ID_W(NB_CH)
) (
    input  logic [NB_CH-1:0] req_i,
`ifndef UDMA_HYPER_ARB_FIXED_PRIO_EN
    input  logic [ID_W-1:0]  ptr_i,
`endif
    output logic [NB_CH-1:0] gnt_o,
    output logic [ID_W-1:0]  idx_o
);

`ifdef UDMA_HYPER_ARB_FIXED_PRIO_EN
    // Lowest-index requester wins.
    always_comb begin
        logic found;
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        for (int i = 0; i < NB_CH; i++) begin
            if (!found && req_i[i]) begin
                found    = 1'b1;
                gnt_o[i] = 1'b1;
                idx_o    = ID_W'(i);
            end
        end
    end
`else
    // First requester at or after the pointer, wrapping modulo NB_CH.
    always_comb begin
        logic            found;
        int              cand;
        logic [ID_W-1:0] cand_idx;
        gnt_o    = '0;
        idx_o    = '0;
        found    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int k = 0; k < NB_CH; k++) begin
            cand = int'(ptr_i) + k;
            if (cand >= NB_CH) cand = cand - NB_CH;
            cand_idx = ID_W'(cand);
            if (!found && req_i[cand_idx]) begin
                found           = 1'b1;
                gnt_o[cand_idx] = 1'b1;
                idx_o           = cand_idx;
            end
        end
    end
`endif

endmodule

// File: rtl/udma_hyper_trans_arb.sv
// HyperBus uDMA transaction arbiter: picks one channel at a time, hands its command
// to the PHY, waits for completion and enforces the read/write recovery gap.
// Build option UDMA_HYPER_ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
module udma_hyper_trans_arb
    import udma_hyper_pkg::*;
#(
    parameter int NB_CH = 2,
    parameter int CMD_W = 64
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    udma_hyper_trans_arb_if.master bus,
    input  logic [31:0]            cfg_t_read_write_recovery_i,
    output logic [NB_CH-1:0]       busy_vec_o,
    output logic                   arb_idle_o
);

    localparam int ID_W = CH_ID_W(NB_CH);

    arb_state_e       state_q, state_d;
    logic [CMD_W-1:0] cmd_q;
    logic [ID_W-1:0]  id_q;
    logic [NB_CH-1:0] busy_q;
    logic [31:0]      cnt_q;

    logic [NB_CH-1:0] arb_gnt;
    logic [ID_W-1:0]  arb_idx;
    logic [NB_CH-1:0] gnt_c;
    logic [NB_CH-1:0] done_c;
    logic             take;
    logic             fin;

    assign take = (state_q == IDLE) && (|bus.ch_req);
    assign fin  = (state_q == ACTIVE) && bus.phy_done;

`ifdef UDMA_HYPER_ARB_FIXED_PRIO_EN
    udma_hyper_rr_arb #(.NB_CH(NB_CH)) i_arb (
        .req_i (bus.ch_req),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx)
    );
`else
    logic [ID_W-1:0] ptr_q;

    udma_hyper_rr_arb #(.NB_CH(NB_CH)) i_arb (
        .req_i (bus.ch_req),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx)
    );

    // Pointer moves past the channel just served so the others go first next time.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else if (take) begin
            ptr_q <= (arb_idx == ID_W'(NB_CH - 1)) ? '0 : arb_idx + 1'b1;
        end
    end
`endif

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic and same-cycle grant.
    always_comb begin
        state_d = state_q;
        gnt_c   = '0;
        unique case (state_q)
            IDLE: begin
                if (|bus.ch_req) begin
                    gnt_c   = arb_gnt;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.phy_ready) state_d = ACTIVE;
            end
            ACTIVE: begin
                if (bus.phy_done) begin
                    state_d = (cfg_t_read_write_recovery_i == 32'd0) ? IDLE : RECOVER;
                end
            end
            RECOVER: begin
                if (cnt_q == 32'd0) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Completion pulse goes to the channel currently owning the PHY.
    always_comb begin
        done_c = '0;
        if (fin) done_c[id_q] = 1'b1;
    end

    // Latched command/id, busy flags and recovery counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: the command latch is reset too, since it drives a visible output that must read 0 after reset.
        if (!rst_ni) begin
            cmd_q  <= '0;
            id_q   <= '0;
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (take) begin
                cmd_q  <= bus.ch_cmd[arb_idx*CMD_W +: CMD_W];
                id_q   <= arb_idx;
                busy_q <= arb_gnt;
            end else if (fin) begin
                busy_q <= '0;
            end

            if (fin && (cfg_t_read_write_recovery_i != 32'd0)) begin
                cnt_q <= cfg_t_read_write_recovery_i - 32'd1;
            end else if ((state_q == RECOVER) && (cnt_q != 32'd0)) begin
                cnt_q <= cnt_q - 32'd1;
            end
        end
    end

    assign bus.ch_gnt    = gnt_c;
    assign bus.ch_done   = done_c;
    assign bus.phy_valid = (state_q == ISSUE);
    assign bus.phy_cmd   = cmd_q;
    assign bus.phy_ch_id = id_q;
    assign busy_vec_o    = busy_q;
    assign arb_idle_o    = (state_q == IDLE);

endmodule
